fifo_wr_arbiter: RTL

Round-robin write-port arbiter for the synchronous FIFO. Shares the single FIFO write port (cs/wr_en/data_in, back-pressured by full) between NUM_REQ producers using valid/ready handshakes. A granted producer owns the port for a burst of up to MAX_BURST words. Ownership passes in rotating priority order, so no producer starves while the FIFO drains.

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// A grant covers one burst of up to MAX_BURST words, ended early by req_last or an abandoned request.

module fifo_wr_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               fifo_cs,
  input logic               fifo_wr_en,
  input logic               busy
);
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_cs_eq_wr      : assert property (@(posedge clk) disable iff (!rst_n) fifo_cs == fifo_wr_en);
  a_wr_only_busy  : assert property (@(posedge clk) disable iff (!rst_n) fifo_wr_en |-> busy);
  a_idle_no_ready : assert property (@(posedge clk) disable iff (!rst_n) !busy |-> (req_ready == '0));
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [ID_W-1:0]  owner_r, owner_nxt_s;
  logic [ID_W-1:0]  rr_ptr_r, rr_ptr_nxt_s;
  logic [ID_W-1:0]  pick_s, owner_inc_s;
  logic [ID_W:0]    scan_s;
  logic [CNT_W-1:0] burst_cnt_r, burst_cnt_nxt_s;
  logic             grant_s, owner_vld_s, xfer_s;
  logic [DATA_WIDTH-1:0] word_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign word_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_s     = (state_r == ST_GRANT);
  assign owner_vld_s = req_valid[owner_r];
  assign xfer_s      = grant_s & owner_vld_s & ~fifo_full;
  assign owner_inc_s = (owner_r == LAST_ID) ? ID_W'(0) : owner_r + ID_W'(1);

  // Round-robin pick: scan offsets high to low so the valid index nearest rr_ptr wins last.
  always_comb begin
    scan_s = '0;
    pick_s = rr_ptr_r;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      scan_s = (scan_s >= (ID_W+1)'(NUM_REQ)) ? scan_s - (ID_W+1)'(NUM_REQ) : scan_s;
      pick_s = req_valid[scan_s[ID_W-1:0]] ? scan_s[ID_W-1:0] : pick_s;
    end
  end

  // Next-state logic for ownership, burst length and rotating priority.
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    burst_cnt_nxt_s = burst_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt_s     = ST_GRANT;
          owner_nxt_s     = pick_s;
          burst_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_vld_s) begin
          // Producer abandoned the burst: release without writing.
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = owner_inc_s;
        end else if (xfer_s) begin
          burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1);
          if (req_last[owner_r] || (burst_cnt_r == LAST_BEAT)) begin
            state_nxt_s  = ST_IDLE;
            rr_ptr_nxt_s = owner_inc_s;
          end else begin
            state_nxt_s = ST_GRANT;
          end
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

  // The write path stays combinational so the FIFO and producer see the same handshake edge.
  assign req_ready    = (grant_s && !fifo_full) ? (NUM_REQ'(1) << owner_r) : '0;
  assign fifo_cs      = xfer_s;
  assign fifo_wr_en   = xfer_s;
  assign fifo_data_in = word_s[owner_r];
  assign grant_id     = owner_r;
  assign busy         = grant_s;

  fifo_wr_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ready  (req_ready),
    .fifo_cs    (fifo_cs),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy)
  );
endmodule
